// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the sprite address generator.
//   anim_state_t  - animation sequencer states (IDLE, PLAY, DONE)
//   ROM_AW        - sprite ROM word-address width
//   SCREEN_W/H    - visible screen dimensions of the VGA timing it pairs with
//   frame_base()  - first ROM word of a given animation frame
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } anim_state_t;

  localparam int unsigned ROM_AW   = 16;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // Frames are stored back to back, so frame n starts n full frames in.
  function automatic logic [ROM_AW-1:0] frame_base(
    input int unsigned idx,
    input int unsigned frame_w,
    input int unsigned frame_h
  );
    return ROM_AW'(idx * frame_w * frame_h);
  endfunction

endpackage

// File: rtl/sprite_anim_fsm.sv
// sprite_anim_fsm: animation sequencer for sprite_addr_gen.
//   Advances frame_idx once every HOLD frame_start pulses while in PLAY.
//   Optional build macro SPRITE_LOOP_EN: wrap to frame 0 and keep playing
//   instead of stopping in DONE.
// Ports:
//   vga_clk      in   pixel clock
//   reset_n      in   synchronous active-low reset
//   frame_start  in   one-cycle pulse at start of vertical blank
//   anim_start   in   one-cycle pulse, (re)starts the animation
//   frame_idx    out  animation frame currently displayed
//   anim_busy    out  1 while in PLAY
//   anim_done    out  one-cycle pulse when the last frame's hold expires
module sprite_anim_fsm
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_FRAMES = 4,
  parameter int unsigned HOLD       = 6,
  localparam int unsigned FI_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic            vga_clk,
  input  logic            reset_n,
  input  logic            frame_start,
  input  logic            anim_start,
  output logic [FI_W-1:0] frame_idx,
  output logic            anim_busy,
  output logic            anim_done
);

  localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  anim_state_t     state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [FI_W-1:0] frame_q, frame_d;
  logic            done_q, done_d;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    // A start request overrides any concurrent frame_start advance.
    if (anim_start) begin
      state_d = PLAY;
      hold_d  = '0;
      frame_d = '0;
    end else if (frame_start && (state_q == PLAY)) begin
      if (hold_q == HW'(HOLD - 1)) begin
        hold_d = '0;
        if (frame_q == FI_W'(NUM_FRAMES - 1)) begin
          done_d = 1'b1;
`ifdef SPRITE_LOOP_EN
          frame_d = '0;
`else
          state_d = DONE;
`endif
        end else begin
          frame_d = frame_q + FI_W'(1);
        end
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end
  end

  always_comb begin
    frame_idx = frame_q;
    anim_busy = (state_q == PLAY);
    anim_done = done_q;
  end

endmodule

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen: scan position to sprite ROM address generator.
//   Latches sprite position/facing on frame_start, hit-tests the scan
//   position against the latched box, and registers a ROM word address
//   one clock after draw_x/draw_y/blank are sampled.
//   Optional build macro SPRITE_LOOP_EN (see sprite_anim_fsm).
// Ports:
//   vga_clk      in   pixel clock
//   reset_n      in   synchronous active-low reset
//   draw_x/y     in   current scan column / row
//   blank        in   1 = active video
//   frame_start  in   one-cycle pulse at start of vertical blank
//   sprite_x/y   in   requested sprite top-left corner
//   facing_left  in   1 = mirror horizontally
//   anim_start   in   one-cycle pulse, (re)starts the animation
//   rom_address  out  ROM word address (0 on a miss)
//   in_sprite    out  1 = rom_address valid for the current pixel
//   anim_busy    out  1 while the animation is playing
//   anim_done    out  one-cycle pulse when the animation completes
//   frame_idx    out  animation frame currently displayed
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int unsigned FRAME_W    = 96,
  parameter int unsigned FRAME_H    = 128,
  parameter int unsigned NUM_FRAMES = 4,
  parameter int unsigned HOLD       = 6,
  localparam int unsigned FI_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic              facing_left,
  input  logic              anim_start,
  output logic [15:0]       rom_address,
  output logic              in_sprite,
  output logic              anim_busy,
  output logic              anim_done,
  output logic [FI_W-1:0]   frame_idx
);

  logic [9:0]        lx_q, lx_d;
  logic [9:0]        ly_q, ly_d;
  logic              lface_q, lface_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic              in_q, in_d;

  logic [10:0]       dx, dy, col;
  logic              hit;
  logic [FI_W-1:0]   fsm_frame;

  sprite_anim_fsm #(
    .NUM_FRAMES (NUM_FRAMES),
    .HOLD       (HOLD)
  ) u_fsm (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .anim_start  (anim_start),
    .frame_idx   (fsm_frame),
    .anim_busy   (anim_busy),
    .anim_done   (anim_done)
  );

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      lx_q    <= '0;
      ly_q    <= '0;
      lface_q <= 1'b0;
      addr_q  <= '0;
      in_q    <= 1'b0;
    end else begin
      lx_q    <= lx_d;
      ly_q    <= ly_d;
      lface_q <= lface_d;
      addr_q  <= addr_d;
      in_q    <= in_d;
    end
  end

  // Position only moves during vertical blank so a frame never tears.
  always_comb begin
    lx_d    = lx_q;
    ly_d    = ly_q;
    lface_d = lface_q;
    if (frame_start) begin
      lx_d    = sprite_x;
      ly_d    = sprite_y;
      lface_d = facing_left;
    end
  end

  // 11-bit differences: the explicit >= tests reject wrapped negatives,
  // so boxes hanging off the right/bottom edge clip without extra logic.
  always_comb begin
    dx  = {1'b0, draw_x} - {1'b0, lx_q};
    dy  = {1'b0, draw_y} - {1'b0, ly_q};
    hit = blank
        & (draw_x >= lx_q) & (dx < 11'(FRAME_W))
        & (draw_y >= ly_q) & (dy < 11'(FRAME_H));
    col = lface_q ? (11'(FRAME_W - 1) - dx) : dx;
  end

  always_comb begin
    addr_d = '0;
    in_d   = 1'b0;
    if (hit) begin
      in_d   = 1'b1;
      addr_d = frame_base(32'(fsm_frame), FRAME_W, FRAME_H)
             + ROM_AW'(dy) * ROM_AW'(FRAME_W)
             + ROM_AW'(col);
    end
  end

  always_comb begin
    rom_address = addr_q;
    in_sprite   = in_q;
    frame_idx   = fsm_frame;
  end

endmodule

// File: tb/tb_sprite_addr_gen.sv
module tb_sprite_addr_gen;

  localparam int FW = 96;
  localparam int FH = 128;
  localparam int NF = 4;
  localparam int HD = 6;

  logic        vga_clk;
  logic        reset_n;
  logic [9:0]  draw_x, draw_y;
  logic        blank;
  logic        frame_start;
  logic [9:0]  sprite_x, sprite_y;
  logic        facing_left;
  logic        anim_start;
  logic [15:0] rom_address;
  logic        in_sprite;
  logic        anim_busy;
  logic        anim_done;
  logic [1:0]  frame_idx;

  int checks   = 0;
  int failures = 0;

  // Reference model: animation tracked as a count of frame_start pulses
  // since the last start; frame index is derived from it by division.
  int m_lx, m_ly, m_face;
  int m_state;   // 0 idle, 1 playing, 2 finished
  int m_pulses;
  int m_done;

  sprite_addr_gen #(
    .FRAME_W    (FW),
    .FRAME_H    (FH),
    .NUM_FRAMES (NF),
    .HOLD       (HD)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .blank       (blank),
    .frame_start (frame_start),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .facing_left (facing_left),
    .anim_start  (anim_start),
    .rom_address (rom_address),
    .in_sprite   (in_sprite),
    .anim_busy   (anim_busy),
    .anim_done   (anim_done),
    .frame_idx   (frame_idx)
  );

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  function automatic int model_frame();
    if (m_state == 1) return (m_pulses / HD) % NF;
    if (m_state == 2) return NF - 1;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock: predict, advance the model, then compare after the edge.
  task automatic cycle();
    int x, y, dx, dy, col, e_addr, e_in;
    e_addr = 0;
    e_in   = 0;
    x = int'(draw_x);
    y = int'(draw_y);
    if (reset_n && blank && x >= m_lx && y >= m_ly && (x - m_lx) < FW && (y - m_ly) < FH) begin
      dx = x - m_lx;
      dy = y - m_ly;
      col = m_face ? (FW - 1 - dx) : dx;
      e_in = 1;
      e_addr = model_frame() * FW * FH + dy * FW + col;
    end
    m_done = 0;
    if (!reset_n) begin
      m_lx = 0; m_ly = 0; m_face = 0; m_state = 0; m_pulses = 0;
    end else begin
      if (anim_start) begin
        m_state = 1;
        m_pulses = 0;
      end else if (frame_start && m_state == 1) begin
        m_pulses++;
        if (m_pulses == HD * NF) begin
          m_done = 1;
`ifdef SPRITE_LOOP_EN
          m_pulses = 0;
`else
          m_state = 2;
`endif
        end
      end
      if (frame_start) begin
        m_lx = int'(sprite_x);
        m_ly = int'(sprite_y);
        m_face = int'(facing_left);
      end
    end
    @(posedge vga_clk);
    #1;
    check("rom_address", 32'(rom_address), 32'(e_addr));
    check("in_sprite",   32'(in_sprite),   32'(e_in));
    check("anim_busy",   32'(anim_busy),   32'(m_state == 1));
    check("anim_done",   32'(anim_done),   32'(m_done));
    check("frame_idx",   32'(frame_idx),   32'(model_frame()));
  endtask

  task automatic scan(input int x, input int y);
    draw_x = 10'(x);
    draw_y = 10'(y);
    cycle();
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    cycle();
  endtask

  initial begin
    int t;
    m_lx = 0; m_ly = 0; m_face = 0; m_state = 0; m_pulses = 0; m_done = 0;
    reset_n = 1'b0; draw_x = '0; draw_y = '0; blank = 1'b1;
    frame_start = 1'b0; sprite_x = '0; sprite_y = '0;
    facing_left = 1'b0; anim_start = 1'b0;

    // Reset state
    cycle();
    cycle();
    check("rst_addr", 32'(rom_address), 32'd0);
    check("rst_in", 32'(in_sprite), 32'd0);
    check("rst_frame", 32'(frame_idx), 32'd0);
    reset_n = 1'b1;

    // Latch (100,200) facing right
    sprite_x = 10'd100; sprite_y = 10'd200; facing_left = 1'b0;
    pulse_fs();
    scan(100, 200);
    check("hit_origin_in", 32'(in_sprite), 32'd1);
    check("hit_origin_addr", 32'(rom_address), 32'd0);
    scan(195, 327);
    check("hit_corner_addr", 32'(rom_address), 32'd12287);
    scan(196, 200);
    check("miss_right_in", 32'(in_sprite), 32'd0);
    scan(100, 328);
    scan(99, 200);

    // Mirrored
    facing_left = 1'b1;
    pulse_fs();
    scan(100, 200);
    check("mirror_left_addr", 32'(rom_address), 32'd95);
    scan(195, 200);
    check("mirror_right_addr", 32'(rom_address), 32'd0);
    check("mirror_right_in", 32'(in_sprite), 32'd1);

    // Animation: 6 pulses advance one frame
    facing_left = 1'b0;
    anim_start = 1'b1;
    cycle();
    anim_start = 1'b0;
    for (int i = 0; i < HD; i++) pulse_fs();
    check("after6_frame", 32'(frame_idx), 32'd1);
    scan(100, 200);
    check("after6_addr", 32'(rom_address), 32'd12288);

    // Mid-frame position change has no effect until frame_start
    sprite_x = 10'd300;
    scan(100, 200);
    check("no_tear_in", 32'(in_sprite), 32'd1);
    pulse_fs();
    scan(100, 200);
    check("moved_miss_in", 32'(in_sprite), 32'd0);
    scan(300, 200);
    sprite_x = 10'd100;
    pulse_fs();
    for (int i = 0; i < 4; i++) pulse_fs();
    check("frame2", 32'(frame_idx), 32'd2);

    // Start coincident with frame_start: restart wins
    anim_start = 1'b1;
    frame_start = 1'b1;
    cycle();
    anim_start = 1'b0;
    frame_start = 1'b0;
    check("restart_frame", 32'(frame_idx), 32'd0);
    check("restart_busy", 32'(anim_busy), 32'd1);

    // Full run: 24 pulses
    for (int i = 0; i < HD * NF - 1; i++) pulse_fs();
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    check("end_done_pulse", 32'(anim_done), 32'd1);
`ifdef SPRITE_LOOP_EN
    check("end_frame", 32'(frame_idx), 32'd0);
    check("end_busy", 32'(anim_busy), 32'd1);
`else
    check("end_frame", 32'(frame_idx), 32'd3);
    check("end_busy", 32'(anim_busy), 32'd0);
`endif
    cycle();
    check("end_done_once", 32'(anim_done), 32'd0);
    pulse_fs();

    // Blanked inside the box
    blank = 1'b0;
    scan(120, 220);
    check("blank_in", 32'(in_sprite), 32'd0);
    blank = 1'b1;

    // Reset mid-play aborts with no done pulse
    anim_start = 1'b1;
    cycle();
    anim_start = 1'b0;
    for (int i = 0; i < 8; i++) pulse_fs();
    draw_x = 10'd120; draw_y = 10'd220;
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    check("midrst_busy", 32'(anim_busy), 32'd0);
    check("midrst_done", 32'(anim_done), 32'd0);
    check("midrst_frame", 32'(frame_idx), 32'd0);
    check("midrst_in", 32'(in_sprite), 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset_n     = ($urandom_range(0, 999) != 0);
      frame_start = ($urandom_range(0, 11) == 0);
      anim_start  = ($urandom_range(0, 399) == 0);
      blank       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) begin
        sprite_x    = 10'($urandom_range(0, 1023));
        sprite_y    = 10'($urandom_range(0, 1023));
        facing_left = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) == 0) begin
        draw_x = 10'($urandom_range(0, 1023));
        draw_y = 10'($urandom_range(0, 1023));
      end else begin
        t = m_lx + int'($urandom_range(0, FW + 8)) - 4;
        draw_x = 10'((t < 0) ? 0 : (t > 1023) ? 1023 : t);
        t = m_ly + int'($urandom_range(0, FH + 8)) - 4;
        draw_y = 10'((t < 0) ? 0 : (t > 1023) ? 1023 : t);
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_addr_gen.md
Name: sprite_addr_gen

Overview:
- Drives the read side of a sprite ROM and palette renderer, such as the kick sprite. It turns the VGA scan position (draw_x, draw_y) plus sprite position, facing and animation state into a 16-bit rom_address and an in_sprite qualifier.
- It sequences a multi-frame animation, advancing one frame every HOLD video frames.
- Sits between the VGA timing controller and the per-move sprite renderer.

Parameters:
- FRAME_W, 96: sprite frame width in pixels.
- FRAME_H, 128: sprite frame height in pixels.
- NUM_FRAMES, 4: number of animation frames, stored consecutively in ROM. NUM_FRAMES*FRAME_W*FRAME_H must be ≤ 65536.
- HOLD, 6: number of frame_start pulses each animation frame is displayed for. Must be ≥ 1.

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- draw_x  in  10  current scan column.
- draw_y  in  10  current scan row.
- blank  in  1  1 = active video. Same polarity as the renderer's blank input.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- sprite_x  in  10  requested sprite left edge.
- sprite_y  in  10  requested sprite top edge.
- facing_left  in  1  1 = mirror horizontally.
- anim_start  in  1  one-cycle pulse that (re)starts the animation.
- rom_address  out  16  ROM word address.
- in_sprite  out  1  1 = rom_address is valid for the current pixel.
- anim_busy  out  1  1 while the FSM is in PLAY.
- anim_done  out  1  one-cycle pulse on entry to DONE.
- frame_idx  out  $clog2(NUM_FRAMES)  animation frame currently displayed.

Behaviour:
- Reset, when reset_n = 0 on a vga_clk edge:
  - rom_address = 0, in_sprite = 0, anim_busy = 0, anim_done = 0, frame_idx = 0.
  - FSM goes to IDLE; hold counter = 0; latched position = 0, latched facing = 0.
  - Reset mid-animation aborts immediately. There is no done pulse.
- Position latch: sprite_x, sprite_y and facing_left are registered only on cycles with frame_start = 1. Changes mid-frame never tear the image.
- Hit test, in 11-bit unsigned arithmetic:
  - dx = draw_x - lx, dy = draw_y - ly.
  - hit = blank & (draw_x ≥ lx) & (dx < FRAME_W) & (draw_y ≥ ly) & (dy < FRAME_H).
  - A sprite that is partially off screen is clipped naturally.
- Column:
  - col = dx when latched facing = 0.
  - col = FRAME_W-1-dx when latched facing = 1.
- Address: rom_address = frame_idx*FRAME_W*FRAME_H + dy*FRAME_W + col.
  - Width is 16 bits with no overflow, given the parameter constraint.
  - Constant multiplies or incremental counters are both acceptable, provided latency is met.
- Latency:
  - draw_x/draw_y/blank sampled at edge N produce rom_address and in_sprite registered at edge N+1.
  - The ROM is read on the falling edge; the renderer registers colour at edge N+2.
- Miss: when hit = 0, rom_address is forced to 0 and in_sprite = 0.
- FSM states:
  - IDLE: shows frame 0, anim_busy = 0.
  - PLAY.
  - DONE: holds the last frame, anim_busy = 0.
- FSM transitions:
  - anim_start in any state: go to PLAY, frame_idx = 0, hold counter = 0. Restarting during PLAY is allowed.
  - In PLAY, each frame_start increments the hold counter.
    - When it reaches HOLD-1, it clears and frame_idx increments.
    - If frame_idx was NUM_FRAMES-1 at that point, go to DONE instead (frame_idx stays). anim_done = 1 for exactly that cycle.
  - frame_start in IDLE or DONE: no FSM effect; the position is still latched.
  - anim_start and frame_start in the same cycle: start wins for the FSM; the position latch still occurs.
- frame_idx changes only on frame_start or anim_start, so there is no mid-frame tearing except on a restart.

Optional Feature:
- SPRITE_LOOP_EN defined:
  - After the last frame's hold expires, PLAY wraps to frame_idx = 0 and stays in PLAY.
  - anim_done pulses once per wrap; DONE is unreachable.
- SPRITE_LOOP_EN undefined: behaviour exactly as specified under Behaviour (stop in DONE).

Decomposition:
- Package sprite_pkg holds:
  - typedef anim_state_t (IDLE, PLAY, DONE);
  - constants ROM_AW = 16, SCREEN_W = 640, SCREEN_H = 480;
  - a function for frame base address.
- One sub-module, sprite_anim_fsm, holds the FSM, hold counter, frame_idx and done pulse.
- The top level holds the position latch, hit test and address pipeline.

Test Plan:
- Reset, then sprite at (100,200) latched by frame_start, facing = 0; scan (100,200) → in_sprite = 1 and rom_address = 0 at the next edge. Scan (195,327) → 12287. Scan (196,200) → in_sprite = 0, address 0.
- facing = 1, same position; scan (100,200) → rom_address = 95; scan (195,200) → 0.
- anim_start, then 6 frame_start pulses → frame_idx = 1 and scan (100,200) → rom_address = 12288. After 24 pulses total → DONE, anim_done high for one cycle, frame_idx = 3, anim_busy = 0.
- sprite_x changed mid-frame with no frame_start → hit region unchanged until the next frame_start.
- anim_start coincident with frame_start during PLAY at frame_idx 2 → frame_idx = 0, hold counter = 0; reset_n low mid-PLAY → IDLE, all outputs 0.
- With SPRITE_LOOP_EN: after 24 pulses → frame_idx = 0, anim_busy = 1, anim_done pulsed; blank = 0 inside the box → in_sprite = 0.
